// File: rtl/run_scan_arbiter_pkg.sv
// Shared types and default sizing for the run-scan arbiter.
// Imported by the interface, the detector and the top.
package run_scan_arbiter_pkg;

  localparam int DEF_WORD_W  = 16;
  localparam int DEF_RUN_LEN = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN,
    REPORT
  } state_t;

endpackage

// File: rtl/run_scan_arbiter_if.sv
// Requester/result bundle for the run-scan arbiter.
// master drives requests, slave is the arbiter.
interface run_scan_arbiter_if
  import run_scan_arbiter_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int RUN_LEN = DEF_RUN_LEN
);

  localparam int CW = $clog2(WORD_W - RUN_LEN + 2);
  localparam int IW = $clog2(WORD_W);

  logic [1:0]        req;
  logic [WORD_W-1:0] data0;
  logic [WORD_W-1:0] data1;
  logic [1:0]        gnt;
  logic              busy;
  logic              done;
  logic              done_id;
  logic [CW-1:0]     hit_count;
  logic              hit_any;
  logic [IW-1:0]     first_hit_idx;

  modport master (
    output req,
    output data0,
    output data1,
    input  gnt,
    input  busy,
    input  done,
    input  done_id,
    input  hit_count,
    input  hit_any,
    input  first_hit_idx
  );

  modport slave (
    input  req,
    input  data0,
    input  data1,
    output gnt,
    output busy,
    output done,
    output done_id,
    output hit_count,
    output hit_any,
    output first_hit_idx
  );

endinterface

// File: rtl/run_scan_arbiter_run_det.sv
// Serial equal-bit run detector; hit is registered and
// asserts when the last RUN_LEN bits seen were all equal.
module run_det #(
  parameter int RUN_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic bit_val,
  output logic hit
);

  localparam int RW = $clog2(RUN_LEN + 1);

  logic [RW-1:0] run;
  logic [RW-1:0] run_nx;
  logic          last;

  // Length of the current run, saturating at RUN_LEN.
  always_comb begin
    run_nx = RW'(1);
    if (run != '0 && bit_val == last) begin
      if (run == RW'(RUN_LEN)) run_nx = run;
      else                     run_nx = run + RW'(1);
    end
  end

  // Run state and registered hit; clear restarts detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run  <= '0;
      last <= 1'b0;
      hit  <= 1'b0;
    end else if (clear) begin
      run  <= '0;
      last <= 1'b0;
      hit  <= 1'b0;
    end else begin
      run  <= run_nx;
      last <= bit_val;
      hit  <= (run_nx == RW'(RUN_LEN));
    end
  end

endmodule

// File: rtl/run_scan_arbiter.sv
// Two-requester round-robin arbiter feeding a serial
// run scanner; reports hit count and first hit index.
module run_scan_arbiter
  import run_scan_arbiter_pkg::*;
#(
  parameter int WORD_W  = DEF_WORD_W,
  parameter int RUN_LEN = DEF_RUN_LEN
) (
  input logic clk,
  input logic reset,
  run_scan_arbiter_if.slave bus
);

  localparam int CW = $clog2(WORD_W - RUN_LEN + 2);
  localparam int IW = $clog2(WORD_W);

  state_t state;
  state_t state_nx;

  logic [1:0]        gnt;
  logic              busy;
  logic              done;
  logic              ptr;
  logic              owner;
  logic [WORD_W-1:0] sr;
  logic [IW-1:0]     cnt;
  logic [IW-1:0]     prev_idx;
  logic              hit;
  logic              det_clr;

  logic [CW-1:0] acc_cnt;
  logic          acc_any;
  logic [IW-1:0] acc_first;
  logic [CW-1:0] cnt_nx;
  logic          any_nx;
  logic [IW-1:0] first_nx;

  logic          res_id;
  logic [CW-1:0] res_cnt;
  logic          res_any;
  logic [IW-1:0] res_first;

  run_det #(
    .RUN_LEN (RUN_LEN)
  ) u_det (
    .clk     (clk),
    .reset   (reset),
    .clear   (det_clr),
    .bit_val (sr[WORD_W-1]),
    .hit     (hit)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (gnt != 2'b00) state_nx = SHIFT;
      SHIFT:  if (cnt == IW'(WORD_W - 1)) state_nx = DRAIN;
      DRAIN:  state_nx = REPORT;
      REPORT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs: round-robin grant in IDLE, busy and done.
  always_comb begin
    gnt = 2'b00;
    if (state == IDLE && reset) begin
      unique case (bus.req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
    busy = (gnt != 2'b00) || (state != IDLE);
    done = (state == REPORT);
  end

  assign det_clr = (gnt != 2'b00);

  // Fold the detector's delayed hit into the accumulators.
  always_comb begin
    cnt_nx   = acc_cnt;
    any_nx   = acc_any;
    first_nx = acc_first;
    if ((state == SHIFT || state == DRAIN) && hit) begin
      cnt_nx = acc_cnt + CW'(1);
      if (!acc_any) begin
        any_nx   = 1'b1;
        first_nx = prev_idx;
      end
    end
  end

  // Job datapath: capture, shift, accumulate, publish.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= 1'b0;
      owner     <= 1'b0;
      sr        <= '0;
      cnt       <= '0;
      prev_idx  <= '0;
      acc_cnt   <= '0;
      acc_any   <= 1'b0;
      acc_first <= '0;
      res_id    <= 1'b0;
      res_cnt   <= '0;
      res_any   <= 1'b0;
      res_first <= '0;
    end else begin
      acc_cnt   <= cnt_nx;
      acc_any   <= any_nx;
      acc_first <= first_nx;
      if (gnt != 2'b00) begin
        sr        <= gnt[1] ? bus.data1 : bus.data0;
        owner     <= gnt[1];
        ptr       <= ~gnt[1];
        cnt       <= '0;
        prev_idx  <= '0;
        acc_cnt   <= '0;
        acc_any   <= 1'b0;
        acc_first <= '0;
      end
      if (state == SHIFT) begin
        sr       <= sr << 1;
        cnt      <= cnt + IW'(1);
        prev_idx <= cnt;
      end
      if (state == DRAIN) begin
        res_id    <= owner;
        res_cnt   <= cnt_nx;
        res_any   <= any_nx;
        res_first <= first_nx;
      end
    end
  end

  assign bus.gnt           = gnt;
  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.done_id       = res_id;
  assign bus.hit_count     = res_cnt;
  assign bus.hit_any       = res_any;
  assign bus.first_hit_idx = res_first;

endmodule
